alien_sprite_engine: RTL

//  Parametrised alien sprite: owns position, bounce motion, bullet collision and a raster scanner

---
 rtl/sprite_pkg.sv | 10 +
 rtl/sprite_scan.sv | 69 ++++++
 rtl/alien_sprite_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, colours and enums for the sprite engines.
package sprite_pkg;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;
    localparam int SUM_W = 10;
    localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
    typedef enum logic [1:0] {IDLE, DRAW, ERASE} state_t;
    typedef enum logic {RIGHT, LEFT} dir_t;
endpackage

// File: rtl/sprite_scan.sv
// sprite_scan: latches a base position and raster-scans a W x H box, one pixel per clk.
module sprite_scan
    import sprite_pkg::*;
#(
    parameter int W = 10,
    parameter int H = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           plot,
    output logic           last
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    logic           active_q, active_d;
    logic [X_W-1:0] bx_q, bx_d;
    logic [Y_W-1:0] by_q, by_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;

    logic col_end, row_end;
    assign col_end = col_q == CW'(W - 1);
    assign row_end = row_q == RW'(H - 1);
    assign x       = bx_q + X_W'(col_q);
    assign y       = by_q + Y_W'(row_q);
    assign plot    = active_q;
    assign last    = active_q && col_end && row_end;

    always_comb begin
        active_d = active_q;
        bx_d     = bx_q;
        by_d     = by_q;
        col_d    = col_q;
        row_d    = row_q;
        if (start) begin
            active_d = 1'b1;
            bx_d     = base_x;
            by_d     = base_y;
            col_d    = '0;
            row_d    = '0;
        end else if (active_q) begin
            col_d    = col_end ? '0 : col_q + 1'b1;
            row_d    = !col_end ? row_q : (row_end ? '0 : row_q + 1'b1);
            active_d = !last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            active_q <= active_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end
endmodule

// File: rtl/alien_sprite_engine.sv
// alien_sprite_engine: alien position, bounce motion, bullet collision and draw/erase
// raster passes feeding the VGA plot mux.
module alien_sprite_engine
    import sprite_pkg::*;
#(
    parameter int               SPR_W   = 10,
    parameter int               SPR_H   = 4,
    parameter int               START_X = 160,
    parameter int               START_Y = 0,
    parameter int               X_MIN   = 0,
    parameter int               X_MAX   = 309,
    parameter int               Y_MAX   = 230,
    parameter int               STEP_X  = 1,
    parameter int               STEP_Y  = 1,
    parameter logic [COL_W-1:0] COLOUR  = 3'b101,
    parameter int               BUL_W   = 2,
    parameter int               BUL_H   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_en,
    input  logic             draw_req,
    input  logic             erase_req,
    input  logic             respawn,
    input  logic             bullet_valid,
    input  logic [X_W-1:0]   bullet_x,
    input  logic [Y_W-1:0]   bullet_y,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             alive,
    output logic             landed
);
    state_t         state_q, state_d;
    dir_t           dir_q, dir_d;
    logic [X_W-1:0] pos_x_q, pos_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d;
    logic           alive_q, alive_d;
    logic           pend_q, pend_d;
    logic           done_q, done_d;
    logic           hit_q, hit_d;
    logic           landed_q, landed_d;
    logic           start, last;

    sprite_scan #(.W(SPR_W), .H(SPR_H)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .base_x (pos_x_q),
        .base_y (pos_y_q),
        .x      (x),
        .y      (y),
        .plot   (plot),
        .last   (last)
    );

    // Motion and overlap arithmetic is widened so edge sums never wrap.
    logic [SUM_W-1:0] px, py, bx, by, x_next;
    logic [Y_W:0]     y_sum;
    logic [Y_W-1:0]   y_inc;
    logic             overlap;
    assign px      = SUM_W'(pos_x_q);
    assign py      = SUM_W'(pos_y_q);
    assign bx      = SUM_W'(bullet_x);
    assign by      = SUM_W'(bullet_y);
    assign x_next  = px + SUM_W'(STEP_X);
    assign y_sum   = (Y_W+1)'(pos_y_q) + (Y_W+1)'(STEP_Y);
    assign y_inc   = y_sum[Y_W] ? '1 : y_sum[Y_W-1:0];
    assign overlap = bx <= px + SUM_W'(SPR_W - 1) && bx + SUM_W'(BUL_W - 1) >= px &&
                     by <= py + SUM_W'(SPR_H - 1) && by + SUM_W'(BUL_H - 1) >= py;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        alive_d = alive_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        start   = 1'b0;
        if (state_q == IDLE) begin
            start   = erase_req || (draw_req && alive_q);
            state_d = erase_req ? ERASE : (start ? DRAW : IDLE);
            done_d  = draw_req && !erase_req && !alive_q;
            pend_d  = 1'b0;
            if ((move_en || pend_q) && alive_q) begin
                if (dir_q == RIGHT) begin
                    if (x_next > SUM_W'(X_MAX)) begin
                        pos_y_d = y_inc;
                        dir_d   = LEFT;
                    end else begin
                        pos_x_d = pos_x_q + X_W'(STEP_X);
                    end
                end else begin
                    if (px < SUM_W'(X_MIN + STEP_X)) begin
                        pos_y_d = y_inc;
                        dir_d   = RIGHT;
                    end else begin
                        pos_x_d = pos_x_q - X_W'(STEP_X);
                    end
                end
            end
        end else begin
            pend_d  = pend_q || move_en;
            state_d = last ? IDLE : state_q;
            done_d  = last;
        end
        hit_d = alive_q && bullet_valid && overlap && !respawn;
        if (alive_q && bullet_valid && overlap) alive_d = 1'b0;
        if (respawn) begin
            pos_x_d = X_W'(START_X);
            pos_y_d = Y_W'(START_Y);
            dir_d   = RIGHT;
            alive_d = 1'b1;
        end
        landed_d = pos_y_d >= Y_W'(Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            dir_q    <= RIGHT;
            pos_x_q  <= X_W'(START_X);
            pos_y_q  <= Y_W'(START_Y);
            alive_q  <= 1'b1;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            alive_q  <= alive_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            landed_q <= landed_d;
        end
    end

    assign colour = (state_q == DRAW) ? COLOUR : COL_BLACK;
    assign busy   = state_q != IDLE;
    assign done   = done_q;
    assign hit    = hit_q;
    assign alive  = alive_q;
    assign landed = landed_q;
endmodule
